// File: rtl/mini_func_pkg.sv
// Shared types and constants for the mini_func forward/inverse pair.
// The golden forward table lives here for reference models.
package mini_func_pkg;

   localparam int A_W  = 3;
   localparam int B_W  = 3;
   localparam int N_IN = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SCAN,
      ST_FLUSH,
      ST_RESP
   } state_t;

   localparam logic [B_W-1:0] F_TABLE [N_IN] = '{
      3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4, 3'd5, 3'd6
   };

endpackage

// File: rtl/mini_func_eval.sv
// Combinational forward function f in sum-of-products form.
// B0 = ~A0, B1 = odd parity of A, B2 = majority of A.
module mini_func_eval
   import mini_func_pkg::*;
(
   input  logic [A_W-1:0] i_a,
   output logic [B_W-1:0] o_b
);

   logic w_a0;
   logic w_a1;
   logic w_a2;

   assign w_a0 = i_a[0];
   assign w_a1 = i_a[1];
   assign w_a2 = i_a[2];

   assign o_b[0] = ~w_a0;

   assign o_b[1] = (~w_a2 & ~w_a1 &  w_a0)
                 | (~w_a2 &  w_a1 & ~w_a0)
                 | ( w_a2 & ~w_a1 & ~w_a0)
                 | ( w_a2 &  w_a1 &  w_a0);

   assign o_b[2] = (w_a2 & w_a1)
                 | (w_a2 & w_a0)
                 | (w_a1 & w_a0);

endmodule

// File: rtl/mini_func_inverse.sv
// Sequential preimage finder: sweeps all inputs through f and reports matches.
// Macro MINI_INV_FIRST_ONLY_EN stops the sweep at the first preimage.
module mini_func_inverse
   import mini_func_pkg::*;
#(
   parameter int FWD_LAT = 0
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req_valid,
   output logic           req_ready,
   input  logic [B_W-1:0] req_target,
   output logic           resp_valid,
   input  logic           resp_ready,
   output logic [N_IN-1:0] resp_mask,
   output logic [3:0]     resp_count,
   output logic [A_W-1:0] resp_first,
   output logic           resp_found
);

   localparam state_t ST_SCAN_EXIT = (FWD_LAT == 1) ? ST_FLUSH : ST_RESP;

   state_t           r_state;
   state_t           w_next;
   logic [B_W-1:0]   r_target;
   logic [A_W-1:0]   r_idx;
   logic [N_IN-1:0]  r_mask;
   logic [3:0]       r_count;
   logic [A_W-1:0]   r_first;
   logic             r_found;
   logic             r_req_ready;
   logic             r_resp_valid;

   logic [B_W-1:0]   w_f;
   logic [B_W-1:0]   w_cmp_b;
   logic [A_W-1:0]   w_cmp_idx;
   logic             w_cmp_vld;
   logic             w_hit;
   logic             w_last;
   logic             w_stop;
   logic             w_accept;
   logic             w_resp_fire;

   mini_func_eval u_eval (
      .i_a (r_idx),
      .o_b (w_f)
   );

   generate
      if (FWD_LAT == 1) begin : g_lat1
         logic [B_W-1:0] r_f_q;
         logic [A_W-1:0] r_idx_q;
         logic           r_vld_q;

         // Forward result register; compare happens one cycle later.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_f_q   <= '0;
               r_idx_q <= '0;
               r_vld_q <= 1'b0;
            end else begin
               r_f_q   <= w_f;
               r_idx_q <= r_idx;
               r_vld_q <= (r_state == ST_SCAN);
            end
         end

         assign w_cmp_b   = r_f_q;
         assign w_cmp_idx = r_idx_q;
         assign w_cmp_vld = r_vld_q &&
                            ((r_state == ST_SCAN) ||
                             (r_state == ST_FLUSH));
      end else begin : g_lat0
         assign w_cmp_b   = w_f;
         assign w_cmp_idx = r_idx;
         assign w_cmp_vld = (r_state == ST_SCAN);
      end
   endgenerate

`ifdef MINI_INV_FIRST_ONLY_EN
   assign w_hit  = w_cmp_vld && (w_cmp_b == r_target) && !r_found;
   assign w_stop = w_last || w_hit;
`else
   assign w_hit  = w_cmp_vld && (w_cmp_b == r_target);
   assign w_stop = w_last;
`endif

   assign w_last      = (r_idx == A_W'(N_IN - 1));
   assign w_accept    = r_req_ready && req_valid;
   assign w_resp_fire = r_resp_valid && resp_ready;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next;
   end

   // Next-state decode.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (w_accept)    w_next = ST_SCAN;
         ST_SCAN:  if (w_stop)      w_next = ST_SCAN_EXIT;
         ST_FLUSH:                  w_next = ST_RESP;
         ST_RESP:  if (w_resp_fire) w_next = ST_IDLE;
         default:                   w_next = ST_IDLE;
      endcase
   end

   // Handshake flags; resp_valid rises one cycle after entering RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_ready  <= 1'b0;
         r_resp_valid <= 1'b0;
      end else begin
         r_req_ready  <= (w_next == ST_IDLE);
         r_resp_valid <= (r_state == ST_RESP) && !w_resp_fire;
      end
   end

   // Scan index, latched target and accumulated result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_target <= '0;
         r_idx    <= '0;
         r_mask   <= '0;
         r_count  <= '0;
         r_first  <= '0;
         r_found  <= 1'b0;
      end else begin
         if (w_accept) begin
            r_target <= req_target;
            r_idx    <= '0;
            r_mask   <= '0;
            r_count  <= '0;
            r_first  <= '0;
            r_found  <= 1'b0;
         end else if (r_state == ST_SCAN) begin
            r_idx <= r_idx + A_W'(1);
         end
         if (w_hit) begin
            r_mask[w_cmp_idx] <= 1'b1;
            r_count           <= r_count + 4'd1;
            if (!r_found) begin
               r_first <= w_cmp_idx;
               r_found <= 1'b1;
            end
         end
      end
   end

   assign req_ready  = r_req_ready;
   assign resp_valid = r_resp_valid;
   assign resp_mask  = r_mask;
   assign resp_count = r_count;
   assign resp_first = r_first;
   assign resp_found = r_found;

endmodule

// File: tb/tb_mini_func_inverse.sv
// Directed bench for mini_func_inverse, FWD_LAT=0 and FWD_LAT=1 side by side.
// Expectations follow MINI_INV_FIRST_ONLY_EN when it is defined.
module tb_mini_func_inverse;
   import mini_func_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic [2:0] req_target;
   logic       resp_ready;

   logic       req_ready0, resp_valid0, resp_found0;
   logic [7:0] resp_mask0;
   logic [3:0] resp_count0;
   logic [2:0] resp_first0;
   logic       req_ready1, resp_valid1, resp_found1;
   logic [7:0] resp_mask1;
   logic [3:0] resp_count1;
   logic [2:0] resp_first1;

   logic [2:0] ev_a;
   logic [2:0] ev_b;

   int total = 0;
   int bad   = 0;
   int l0, l1;
   int sum;
   int sb_cnt;
   bit seen;

   localparam logic [7:0] EM [8] = '{8'h00, 8'h01, 8'h02, 8'h14,
                                     8'h28, 8'h40, 8'h80, 8'h00};
   localparam int EC [8] = '{0, 1, 1, 2, 2, 1, 1, 0};
   localparam int EF [8] = '{0, 0, 1, 2, 3, 6, 7, 0};
   localparam logic [2:0] EB [8] = '{3'd1, 3'd2, 3'd3, 3'd4,
                                     3'd3, 3'd4, 3'd5, 3'd6};

   always #5 clk = ~clk;

   mini_func_inverse #(.FWD_LAT(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready0),
      .req_target(req_target),
      .resp_valid(resp_valid0), .resp_ready(resp_ready),
      .resp_mask(resp_mask0), .resp_count(resp_count0),
      .resp_first(resp_first0), .resp_found(resp_found0)
   );

   mini_func_inverse #(.FWD_LAT(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready1),
      .req_target(req_target),
      .resp_valid(resp_valid1), .resp_ready(resp_ready),
      .resp_mask(resp_mask1), .resp_count(resp_count1),
      .resp_first(resp_first1), .resp_found(resp_found1)
   );

   mini_func_eval u_ev (.i_a(ev_a), .o_b(ev_b));

   function automatic logic [7:0] em(input int t);
`ifdef MINI_INV_FIRST_ONLY_EN
      return (EC[t] == 0) ? 8'h00 : 8'(1 << EF[t]);
`else
      return EM[t];
`endif
   endfunction

   function automatic int ec(input int t);
`ifdef MINI_INV_FIRST_ONLY_EN
      return (EC[t] == 0) ? 0 : 1;
`else
      return EC[t];
`endif
   endfunction

   function automatic int elat0(input int t);
`ifdef MINI_INV_FIRST_ONLY_EN
      return (EC[t] == 0) ? 9 : EF[t] + 2;
`else
      return 9;
`endif
   endfunction

   function automatic int elat1(input int t);
`ifdef MINI_INV_FIRST_ONLY_EN
      if (EC[t] == 0) return 10;
      return (EF[t] + 4 > 10) ? 10 : EF[t] + 4;
`else
      return 10;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ready();
      for (int c = 0; c < 20 && !(req_ready0 && req_ready1); c++) begin
         @(posedge clk); #1;
      end
      chk("req_ready", {31'd0, req_ready0 & req_ready1}, 1);
   endtask

   task automatic issue(input logic [2:0] t);
      wait_ready();
      req_valid  = 1'b1;
      req_target = t;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_target = ~t;
   endtask

   task automatic collect();
      l0 = -1;
      l1 = -1;
      for (int c = 1; c <= 30; c++) begin
         @(posedge clk); #1;
         if (resp_valid0 && l0 < 0) l0 = c;
         if (resp_valid1 && l1 < 0) l1 = c;
         if (l0 >= 0 && l1 >= 0) break;
      end
   endtask

   task automatic check_out(input int t);
      chk($sformatf("lat0 t%0d", t), l0, elat0(t));
      chk($sformatf("lat1 t%0d", t), l1, elat1(t));
      chk($sformatf("mask0 t%0d", t), resp_mask0, em(t));
      chk($sformatf("cnt0 t%0d", t), resp_count0, ec(t));
      chk($sformatf("first0 t%0d", t), resp_first0, EF[t]);
      chk($sformatf("found0 t%0d", t), resp_found0, EC[t] != 0);
      chk($sformatf("mask1 t%0d", t), resp_mask1, em(t));
      chk($sformatf("cnt1 t%0d", t), resp_count1, ec(t));
      chk($sformatf("first1 t%0d", t), resp_first1, EF[t]);
      chk($sformatf("found1 t%0d", t), resp_found1, EC[t] != 0);
   endtask

   task automatic handshake(input int t);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("valid drop0", resp_valid0, 0);
      chk("valid drop1", resp_valid1, 0);
      chk($sformatf("mask kept t%0d", t), resp_mask0, em(t));
   endtask

   task automatic txn(input logic [2:0] t);
      issue(t);
      collect();
      check_out(int'(t));
      handshake(int'(t));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_target = 3'd0;
      resp_ready = 1'b0;
      ev_a       = 3'd0;

      #3;
      chk("rst req_ready0", req_ready0, 0);
      chk("rst req_ready1", req_ready1, 0);
      chk("rst valid0", resp_valid0, 0);
      chk("rst mask0", resp_mask0, 0);
      chk("rst cnt0", resp_count0, 0);
      chk("rst first0", resp_first0, 0);
      chk("rst found0", resp_found0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst hold ready0", req_ready0, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post rst ready0", req_ready0, 1);
      chk("post rst ready1", req_ready1, 1);

      for (int i = 0; i < 8; i++) begin
         ev_a = 3'(i);
         #1;
         chk($sformatf("eval a%0d", i), ev_b, EB[i]);
      end

      txn(3'd3);
      txn(3'd4);
      txn(3'd6);
      txn(3'd0);
      txn(3'd7);

      sum = 0;
      for (int t = 0; t < 8; t++) begin
         sb_cnt = 0;
         for (int i = 0; i < N_IN; i++)
            if (F_TABLE[i] == 3'(t)) sb_cnt++;
`ifdef MINI_INV_FIRST_ONLY_EN
         if (sb_cnt > 1) sb_cnt = 1;
`endif
         txn(3'(t));
         chk($sformatf("sb cnt t%0d", t), resp_count0, sb_cnt);
         sum += int'(resp_count0);
      end
`ifdef MINI_INV_FIRST_ONLY_EN
      chk("sweep sum", sum, 6);
`else
      chk("sweep sum", sum, 8);
`endif

      issue(3'd5);
      collect();
      check_out(5);
      req_valid  = 1'b1;
      req_target = 3'd2;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("hold mask0", resp_mask0, 8'h40);
         chk("hold valid0", resp_valid0, 1);
         chk("hold ready0", req_ready0, 0);
      end
      chk("hold mask1", resp_mask1, 8'h40);
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("after hs ready0", req_ready0, 1);
      chk("after hs valid0", resp_valid0, 0);
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_target = 3'd5;
      chk("accepted ready0", req_ready0, 0);
      chk("accept clr mask0", resp_mask0, 0);
      collect();
      check_out(2);
      handshake(2);

      issue(3'd3);
      repeat (4) @(posedge clk);
      #1;
      chk("mid scan mask0", resp_mask0, 8'h04);
      chk("mid scan mask1", resp_mask1, 8'h04);
      rst_n = 1'b0;
      #1;
      chk("mid rst mask0", resp_mask0, 0);
      chk("mid rst cnt0", resp_count0, 0);
      chk("mid rst found0", resp_found0, 0);
      chk("mid rst valid0", resp_valid0, 0);
      chk("mid rst ready0", req_ready0, 0);
      chk("mid rst mask1", resp_mask1, 0);
      @(negedge clk) rst_n = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (resp_valid0 || resp_valid1) seen = 1'b1;
      end
      chk("no stale resp", seen, 0);
      txn(3'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
